// File: rtl/keccak_pad_absorb.sv
// Keccak/SHA-3 message absorber: packs DWIDTH-bit beats into rate-sized blocks,
// applies the SHA3/SHAKE pad10*1 rule to the final block, and hands blocks out over a valid/ready port.
module keccak_pad_absorb #(
  parameter int DWIDTH         = 256,
  parameter int MAX_RATE_BYTES = 168
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic [DWIDTH-1:0]           in_data_i,
  input  logic [DWIDTH/8-1:0]         in_keep_i,
  input  logic                        in_last_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [MAX_RATE_BYTES*8-1:0] blk_o,
  output logic                        blk_valid_o,
  input  logic                        blk_ready_i,
  output logic                        blk_last_o,
  output logic                        busy_o
);

  localparam int BB = DWIDTH / 8;
  localparam int BW = MAX_RATE_BYTES * 8;
  localparam int CW = BB * 8;
  localparam int WB = (MAX_RATE_BYTES + BB) * 8;

  typedef enum logic [2:0] {IDLE, ABSORB, EMIT, PAD, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   carry_q, carry_d;
  logic [7:0]      carry_cnt_q, carry_cnt_d;
  logic            last_q, last_d;
  logic            final_q, final_d;

  logic [7:0]      rate;
  logic [7:0]      suffix;
  logic [7:0]      n;
  logic [DWIDTH-1:0] mask;
  logic [8:0]      sum;
  logic [WB-1:0]   shifted;
  logic [WB-1:0]   rate_mask;
  logic [BW-1:0]   absorbed;
  logic [CW-1:0]   carry_in;
  logic [BW-1:0]   suffix_vec;
  logic [BW-1:0]   top_vec;

  always_comb begin
    rate = 8'd136;
    case (mode_q)
      2'd1:    rate = 8'd72;
      2'd2:    rate = 8'd168;
      default: rate = 8'd136;
    endcase
    suffix = mode_q[1] ? 8'h1F : 8'h06;
  end

  // Keep is contiguous from byte 0, so the shifted masked beat lands at offset cnt;
  // anything shifted past the rate boundary is exactly the carry.
  always_comb begin
    n    = '0;
    mask = '0;
    for (int i = 0; i < BB; i++) begin
      n = n + 8'(in_keep_i[i]);
      mask[i*8 +: 8] = {8{in_keep_i[i]}};
    end
  end

  assign sum        = {1'b0, cnt_q} + {1'b0, n};
  assign shifted    = WB'(in_data_i & mask) << {cnt_q, 3'b000};
  assign rate_mask  = ~({WB{1'b1}} << {rate, 3'b000});
  assign absorbed   = BW'(shifted & rate_mask);
  assign carry_in   = CW'(shifted >> {rate, 3'b000});
  assign suffix_vec = BW'(suffix) << {cnt_q, 3'b000};
  assign top_vec    = BW'(8'h80) << {rate - 8'd1, 3'b000};

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    carry_d     = carry_q;
    carry_cnt_d = carry_cnt_q;
    last_d      = last_q;
    final_d     = final_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d      = mode_i;
          cnt_d       = '0;
          buf_d       = '0;
          carry_d     = '0;
          carry_cnt_d = '0;
          last_d      = 1'b0;
          final_d     = 1'b0;
          state_d     = ABSORB;
        end
      end
      ABSORB: begin
        if (in_valid_i && (n != 8'd0 || in_last_i)) begin
          buf_d = buf_q | absorbed;
          if (sum >= {1'b0, rate}) begin
            cnt_d       = rate;
            carry_d     = carry_in;
            carry_cnt_d = 8'(sum - {1'b0, rate});
            last_d      = in_last_i;
            state_d     = EMIT;
          end else begin
            cnt_d = sum[7:0];
            if (in_last_i) state_d = PAD;
          end
        end
      end
      PAD: begin
        buf_d   = (buf_q ^ suffix_vec) | top_vec;
        final_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (blk_ready_i) begin
          buf_d       = BW'(carry_q);
          cnt_d       = carry_cnt_q;
          carry_d     = '0;
          carry_cnt_d = '0;
          if (final_q) begin
            state_d = DONE;
          end else if (last_q) begin
            // Last beat was absorbed without room to pad: a separate pad block follows.
            last_d  = 1'b0;
            state_d = PAD;
          end else begin
            state_d = ABSORB;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the block buffer and carry are reset too, so an aborted message leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      carry_q     <= '0;
      carry_cnt_q <= '0;
      last_q      <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      carry_q     <= carry_d;
      carry_cnt_q <= carry_cnt_d;
      last_q      <= last_d;
      final_q     <= final_d;
    end
  end

  assign in_ready_o  = (state_q == ABSORB) && !rst;
  assign blk_valid_o = (state_q == EMIT) && !rst;
  assign blk_last_o  = (state_q == EMIT) && final_q && !rst;
  assign busy_o      = (state_q != IDLE) && !rst;
  assign blk_o       = rst ? '0 : buf_q;

endmodule

// File: tb/tb_keccak_pad_absorb.sv
// Directed bench for keccak_pad_absorb (DWIDTH=256): empty message, single and multi-block
// messages with padding, straddling carry, output backpressure and mid-message reset.
module tb_keccak_pad_absorb;

  localparam int DW = 256;
  localparam int BB = DW / 8;
  localparam int MR = 168;
  localparam int BW = MR * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [DW-1:0] in_data_i;
  logic [BB-1:0] in_keep_i;
  logic          in_last_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [BW-1:0] blk_o;
  logic          blk_valid_o;
  logic          blk_ready_i;
  logic          blk_last_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] got_blk[$];
  logic          got_last[$];

  keccak_pad_absorb #(.DWIDTH(DW), .MAX_RATE_BYTES(MR)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .in_data_i(in_data_i), .in_keep_i(in_keep_i), .in_last_i(in_last_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .blk_o(blk_o), .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
    .blk_last_o(blk_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 37 + 11) % 256);
  endfunction

  function automatic int rate_of(input logic [1:0] m);
    case (m)
      2'd1:    return 72;
      2'd2:    return 168;
      default: return 136;
    endcase
  endfunction

  // Reference padded block b of a len-byte message: data bytes, then suffix at the
  // first free byte of the last block and 0x80 OR'd into its final rate byte.
  function automatic logic [BW-1:0] exp_block(input logic [1:0] m, input int len, input int b);
    int r = rate_of(m);
    int nb = len / r + 1;
    logic [7:0] s = m[1] ? 8'h1F : 8'h06;
    logic [BW-1:0] v = '0;
    for (int j = 0; j < r; j++)
      if (b * r + j < len) v[j*8 +: 8] = pat(b * r + j);
    if (b == nb - 1) begin
      v[(len - b * r)*8 +: 8] = v[(len - b * r)*8 +: 8] ^ s;
      v[(r - 1)*8 +: 8]       = v[(r - 1)*8 +: 8] | 8'h80;
    end
    return v;
  endfunction

  function automatic int first_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int j = 0; j < MR; j++)
      if (a[j*8 +: 8] !== b[j*8 +: 8]) return j;
    return -1;
  endfunction

  // All driver tasks are entered and left at a falling edge.
  task automatic start_msg(input logic [1:0] m);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drive_beat(input int base, input int nb, input logic last);
    int waited = 0;
    in_data_i = '0;
    in_keep_i = '0;
    for (int i = 0; i < BB; i++) begin
      if (i < nb) begin
        in_data_i[i*8 +: 8] = pat(base + i);
        in_keep_i[i]        = 1'b1;
      end else begin
        in_data_i[i*8 +: 8] = 8'hA5;
      end
    end
    in_last_i  = last;
    in_valid_i = 1'b1;
    while (!in_ready_o) begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        n_checks++; n_fail++;
        $display("FAIL beat_timeout: beat at byte %0d not accepted, in_ready_o=%b required 1", base, in_ready_o);
        break;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic send_msg(input int len, input bit gap);
    if (len == 0) begin
      drive_beat(0, 0, 1'b1);
    end else begin
      for (int b = 0; b < len; b += BB) begin
        int nb = (len - b < BB) ? len - b : BB;
        drive_beat(b, nb, (b + nb >= len));
        if (gap && b == 0) drive_beat(0, 0, 1'b0);
      end
    end
  endtask

  task automatic recv_blocks(input int count);
    int waited = 0;
    int got = 0;
    while (got < count) begin
      if (blk_valid_o && blk_ready_i) begin
        got_blk.push_back(blk_o);
        got_last.push_back(blk_last_o);
        got++;
      end
      @(negedge clk);
      waited++;
      if (waited > 600) begin
        n_checks++; n_fail++;
        $display("FAIL recv_timeout: got %0d blocks, required %0d", got, count);
        break;
      end
    end
  endtask

  task automatic run_msg(input logic [1:0] m, input int len, input bit gap);
    got_blk.delete();
    got_last.delete();
    start_msg(m);
    fork
      send_msg(len, gap);
      recv_blocks(len / rate_of(m) + 1);
    join
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done: busy_o=%b required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; mode_i = '0; in_data_i = '0; in_keep_i = '0;
    in_last_i = 1'b0; in_valid_i = 1'b0; blk_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: %b required 0", in_ready_o); end
    n_checks++; if (blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_blk_valid: %b required 0", blk_valid_o); end
    n_checks++; if (blk_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_blk_last: %b required 0", blk_last_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b required 0", busy_o); end
    n_checks++; if (blk_o !== '0) begin n_fail++; $display("FAIL reset_blk: byte %0d nonzero", first_diff(blk_o, '0)); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy_o=%b required 0", busy_o); end
  endtask

  task automatic test_empty_sha3_256();
    logic [BW-1:0] e = '0;
    logic [BW-1:0] b0;
    e[7:0]        = 8'h06;
    e[135*8 +: 8] = 8'h80;
    run_msg(2'd0, 0, 1'b0);
    b0 = got_blk[0];
    n_checks++; if (b0 !== e) begin n_fail++; $display("FAIL empty_block: byte %0d got %h required %h", first_diff(b0, e), b0[first_diff(b0, e)*8 +: 8], e[first_diff(b0, e)*8 +: 8]); end
    n_checks++; if (got_last[0] !== 1'b1) begin n_fail++; $display("FAIL empty_last: %b required 1", got_last[0]); end
  endtask

  task automatic test_shake128_167();
    logic [BW-1:0] b0, e;
    run_msg(2'd2, 167, 1'b0);
    b0 = got_blk[0];
    e  = exp_block(2'd2, 167, 0);
    n_checks++; if (b0[167*8 +: 8] !== 8'h9F) begin n_fail++; $display("FAIL shake_byte167: %h required 9f", b0[167*8 +: 8]); end
    n_checks++; if (b0 !== e) begin n_fail++; $display("FAIL shake_block: byte %0d got %h required %h", first_diff(b0, e), b0[first_diff(b0, e)*8 +: 8], e[first_diff(b0, e)*8 +: 8]); end
    n_checks++; if (got_last[0] !== 1'b1) begin n_fail++; $display("FAIL shake_last: %b required 1", got_last[0]); end
  endtask

  task automatic test_sha3_512_72();
    logic [BW-1:0] b, e;
    run_msg(2'd1, 72, 1'b0);
    for (int k = 0; k < 2; k++) begin
      b = got_blk[k];
      e = exp_block(2'd1, 72, k);
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL sha512_blk%0d: byte %0d got %h required %h", k, first_diff(b, e), b[first_diff(b, e)*8 +: 8], e[first_diff(b, e)*8 +: 8]); end
      n_checks++; if (got_last[k] !== (k == 1)) begin n_fail++; $display("FAIL sha512_last%0d: %b required %b", k, got_last[k], (k == 1)); end
    end
    b = got_blk[1];
    n_checks++; if (b[7:0] !== 8'h06 || b[71*8 +: 8] !== 8'h80) begin n_fail++; $display("FAIL sha512_padblk: byte0=%h byte71=%h required 06/80", b[7:0], b[71*8 +: 8]); end
  endtask

  task automatic test_sha3_256_160_carry();
    logic [BW-1:0] b, e;
    run_msg(2'd0, 160, 1'b1);
    for (int k = 0; k < 2; k++) begin
      b = got_blk[k];
      e = exp_block(2'd0, 160, k);
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL carry_blk%0d: byte %0d got %h required %h", k, first_diff(b, e), b[first_diff(b, e)*8 +: 8], e[first_diff(b, e)*8 +: 8]); end
      n_checks++; if (got_last[k] !== (k == 1)) begin n_fail++; $display("FAIL carry_last%0d: %b required %b", k, got_last[k], (k == 1)); end
    end
    b = got_blk[1];
    n_checks++; if (b[7:0] !== pat(136) || b[24*8 +: 8] !== 8'h06 || b[135*8 +: 8] !== 8'h80) begin
      n_fail++; $display("FAIL carry_bytes: byte0=%h byte24=%h byte135=%h required %h/06/80", b[7:0], b[24*8 +: 8], b[135*8 +: 8], pat(136));
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] snap, b, e;
    got_blk.delete();
    got_last.delete();
    blk_ready_i = 1'b0;
    start_msg(2'd1);
    drive_beat(0, 32, 1'b0);
    drive_beat(32, 32, 1'b0);
    drive_beat(64, 32, 1'b0);
    n_checks++; if (blk_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_latency: blk_valid_o=%b required 1", blk_valid_o); end
    snap = blk_o;
    in_data_i = '0;
    for (int i = 0; i < 4; i++) in_data_i[i*8 +: 8] = pat(96 + i);
    in_keep_i = 32'h0000_000F;
    in_last_i = 1'b1;
    in_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (blk_o !== snap || in_ready_o !== 1'b0 || blk_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: stable=%b in_ready_o=%b blk_valid_o=%b required 1/0/1", c, (blk_o === snap), in_ready_o, blk_valid_o);
      end
    end
    blk_ready_i = 1'b1;
    fork
      drive_beat(96, 4, 1'b1);
      recv_blocks(2);
    join
    for (int k = 0; k < 2; k++) begin
      b = got_blk[k];
      e = exp_block(2'd1, 100, k);
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL bp_blk%0d: byte %0d got %h required %h", k, first_diff(b, e), b[first_diff(b, e)*8 +: 8], e[first_diff(b, e)*8 +: 8]); end
      n_checks++; if (got_last[k] !== (k == 1)) begin n_fail++; $display("FAIL bp_last%0d: %b required %b", k, got_last[k], (k == 1)); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] b0, e;
    start_msg(2'd0);
    drive_beat(0, 32, 1'b0);
    drive_beat(32, 8, 1'b0);
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_absorbing: in_ready_o=%b required 1", in_ready_o); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready_o !== 1'b0 || blk_valid_o !== 1'b0 || blk_last_o !== 1'b0 || busy_o !== 1'b0 || blk_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b last=%b busy=%b blk_zero=%b required 0/0/0/0/1",
               in_ready_o, blk_valid_o, blk_last_o, busy_o, (blk_o === '0));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (blk_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_block: valid=%b busy=%b required 0/0", blk_valid_o, busy_o); end
    run_msg(2'd0, 0, 1'b0);
    b0 = got_blk[0];
    e  = exp_block(2'd0, 0, 0);
    n_checks++; if (b0 !== e) begin n_fail++; $display("FAIL mid_next_block: byte %0d got %h required %h", first_diff(b0, e), b0[first_diff(b0, e)*8 +: 8], e[first_diff(b0, e)*8 +: 8]); end
    n_checks++; if (got_last[0] !== 1'b1) begin n_fail++; $display("FAIL mid_next_last: %b required 1", got_last[0]); end
  endtask

  initial begin
    test_reset();
    test_empty_sha3_256();
    test_shake128_167();
    test_sha3_512_72();
    test_sha3_256_160_carry();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
